// File: rtl/vector_alu_pkg.sv
// Shared definitions for the sequential vector ALU: opcodes, FSM states and
// the lane saturation clamp helper.
package vector_alu_pkg;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_PASS  = 5'b00001;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_AND   = 5'b00011;
  localparam logic [4:0] OP_OR    = 5'b00100;
  localparam logic [4:0] OP_XOR   = 5'b00101;
  localparam logic [4:0] OP_ADDS  = 5'b00110;
  localparam logic [4:0] OP_SUBS  = 5'b00111;
  localparam logic [4:0] OP_MUL   = 5'b01000;
  localparam logic [4:0] OP_MULHI = 5'b01001;
  localparam logic [4:0] OP_CMP   = 5'b01010;
  localparam logic [4:0] OP_PASS2 = 5'b01011;
  localparam logic [4:0] OP_NOP   = 5'b11111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Signed clamp for an lw-bit lane, right-aligned in 64 bits: min if neg, else max.
  function automatic logic [63:0] lane_clamp(input logic neg, input int unsigned lw);
    lane_clamp = neg ? (64'd1 << (lw - 1)) : ((64'd1 << (lw - 1)) - 64'd1);
  endfunction

endpackage

// File: rtl/vector_alu_seq_lane.sv
// One packed lane of wrapping or signed-saturating add/subtract.
module lane_addsub_sat
  import vector_alu_pkg::*;
#(
  parameter int LW = 16
) (
  input  logic signed [LW-1:0] a,
  input  logic signed [LW-1:0] b,
  input  logic                 sub,
  input  logic                 sat_en,
  output logic signed [LW-1:0] y,
  output logic                 ovf
);

  logic signed [LW-1:0] bb;
  logic signed [LW-1:0] sum;
  logic                 raw_ovf;

  function automatic logic signed [LW-1:0] sat_clamp(input logic neg);
    logic [63:0] c;
    c = lane_clamp(neg, LW);
    return c[LW-1:0];
  endfunction

  // Subtract is a + ~b + 1, so both cases share one overflow rule on (a, bb).
  always_comb begin
    bb      = sub ? ~b : b;
    sum     = a + bb + {{(LW-1){1'b0}}, sub};
    raw_ovf = (a[LW-1] == bb[LW-1]) && (sum[LW-1] != a[LW-1]);
    ovf     = sat_en && raw_ovf;
    y       = ovf ? sat_clamp(a[LW-1]) : sum;
  end

endmodule

// File: rtl/vector_alu_seq.sv
// Registered vector ALU with valid/ready on both sides and a bit-serial
// signed multiplier that keeps the upper product half for MULHI.
module vector_alu_seq
  import vector_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = 2,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [LANES-1:0] sat,
  output logic             busy
);

  localparam int LW = WIDTH / LANES;
  localparam int CW = $clog2(WIDTH) + 1;

  state_t             state;
  logic [4:0]         opc;
  logic               accept;
  logic [WIDTH-1:0]   lane_y;
  logic [LANES-1:0]   lane_ovf;
  logic               lane_sub;
  logic               lane_sat_en;
  logic [WIDTH-1:0]   alu_y;
  logic [LANES-1:0]   alu_sat;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   hi;
  logic               neg;
  logic [CW-1:0]      cnt;
  logic signed [WIDTH-1:0] r_sg;
  logic signed [WIDTH-1:0] s_sg;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   s_mag;

  assign opc         = 5'(op);
  assign in_ready    = (state == IDLE) && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign lane_sub    = (opc == OP_SUB) || (opc == OP_SUBS);
  assign lane_sat_en = (opc == OP_ADDS) || (opc == OP_SUBS);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_addsub_sat #(.LW(LW)) u_lane (
      .a      (r[g*LW +: LW]),
      .b      (s[g*LW +: LW]),
      .sub    (lane_sub),
      .sat_en (lane_sat_en),
      .y      (lane_y[g*LW +: LW]),
      .ovf    (lane_ovf[g])
    );
  end

  always_comb begin
    alu_y   = s;
    alu_sat = '0;
    case (opc)
      OP_ADD, OP_SUB:   alu_y = lane_y;
      OP_ADDS, OP_SUBS: begin
        alu_y   = lane_y;
        alu_sat = lane_ovf;
      end
      OP_AND:   alu_y = r & s;
      OP_OR:    alu_y = r | s;
      OP_XOR:   alu_y = r ^ s;
      OP_MULHI: alu_y = hi;
      OP_CMP:   alu_y = ((r & s) == r) ? '1 : '0;
      default:  alu_y = s;
    endcase
  end

  // Magnitudes are unsigned, so the most negative input maps to 2^(WIDTH-1).
  always_comb begin
    r_sg      = r;
    s_sg      = s;
    r_mag     = r_sg[WIDTH-1] ? WIDTH'(-r_sg) : r;
    s_mag     = s_sg[WIDTH-1] ? WIDTH'(-s_sg) : s;
    acc       = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_step = {acc, prod[WIDTH-1:1]};
    prod_fix  = neg ? -prod : prod;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      y         <= '0;
      sat       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      hi        <= '0;
      prod      <= '0;
      mcand     <= '0;
      neg       <= 1'b0;
      cnt       <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (opc == OP_MUL) begin
              state <= MUL;
              mcand <= r_mag;
              prod  <= {{WIDTH{1'b0}}, s_mag};
              neg   <= r[WIDTH-1] ^ s[WIDTH-1];
              cnt   <= '0;
              busy  <= 1'b1;
            end else if (opc != OP_NOP) begin
              y         <= alu_y;
              sat       <= alu_sat;
              out_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          prod <= prod_step;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          y         <= prod_fix[WIDTH-1:0];
          hi        <= prod_fix[2*WIDTH-1:WIDTH];
          sat       <= '0;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_alu_seq.sv
// Directed bench for vector_alu_seq (WIDTH=32, LANES=2): vector table for
// single-cycle ops plus hand sequences for multiply, backpressure, reset, NOP.
module tb_vector_alu_seq;

  localparam int W     = 32;
  localparam int L     = 2;
  localparam int LIMIT = 60;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [4:0]   op = 5'd0;
  logic [W-1:0] r = '0;
  logic [W-1:0] s = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] y;
  logic [L-1:0] sat;
  logic         busy;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  vector_alu_seq #(.WIDTH(W), .LANES(L), .OPW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .r         (r),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .sat       (sat),
    .busy      (busy)
  );

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] r;
    logic [W-1:0] s;
    logic [W-1:0] y;
    logic [L-1:0] sat;
  } vec_t;

  vec_t tv[16];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // lat = edges after the accept edge until out_valid is seen (LIMIT if never);
  // bcnt = sampled cycles with busy high while waiting.
  task automatic issue(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int bcnt);
    int n;
    n = 0;
    @(negedge clk);
    op = o; r = a; s = b; in_valid = 1'b1;
    while (!in_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (!out_valid && lat < LIMIT) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, seen;

    tv[0]  = '{5'b01001, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 2'b00}; // MULHI before MUL
    tv[1]  = '{5'b00000, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 2'b00};
    tv[2]  = '{5'b00000, 32'h0000_FFFF, 32'h0000_0001, 32'h0000_0000, 2'b00};
    tv[3]  = '{5'b00110, 32'h7FFF_8000, 32'h0001_8000, 32'h7FFF_8000, 2'b11};
    tv[4]  = '{5'b00111, 32'h0000_0000, 32'h0000_8000, 32'h0000_7FFF, 2'b01};
    tv[5]  = '{5'b00010, 32'h0000_0000, 32'h0000_0001, 32'h0000_FFFF, 2'b00};
    tv[6]  = '{5'b00010, 32'h0000_0005, 32'h0002_0003, 32'hFFFE_0002, 2'b00};
    tv[7]  = '{5'b00011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 2'b00};
    tv[8]  = '{5'b00100, 32'h0F0F_0000, 32'h00F0_000F, 32'h0FFF_000F, 2'b00};
    tv[9]  = '{5'b00101, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 2'b00};
    tv[10] = '{5'b00001, 32'h0000_1234, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00};
    tv[11] = '{5'b01010, 32'h0000_000F, 32'h0000_00FF, 32'hFFFF_FFFF, 2'b00};
    tv[12] = '{5'b01010, 32'h0000_000F, 32'h0000_00F0, 32'h0000_0000, 2'b00};
    tv[13] = '{5'b01011, 32'h1111_1111, 32'hCAFE_F00D, 32'hCAFE_F00D, 2'b00};
    tv[14] = '{5'b01100, 32'h1111_1111, 32'h1234_5678, 32'h1234_5678, 2'b00};
    tv[15] = '{5'b00110, 32'h0001_0002, 32'h0003_0004, 32'h0004_0006, 2'b00};

    #1;
    chk("rst_y", y, 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 16; i++) begin
      issue(tv[i].op, tv[i].r, tv[i].s, lat, bcnt);
      chk($sformatf("row%0d_lat", i), 32'(lat), 32'd0);
      chk($sformatf("row%0d_y", i), y, tv[i].y);
      chk($sformatf("row%0d_sat", i), 32'(sat), 32'(tv[i].sat));
    end

    // Signed multiply -3 * 7
    issue(5'b01000, 32'hFFFF_FFFD, 32'h0000_0007, lat, bcnt);
    chk("mul_lat", 32'(lat), 32'd33);
    chk("mul_busy_cycles", 32'(bcnt), 32'd33);
    chk("mul_busy_done", 32'(busy), 32'd0);
    chk("mul_y", y, 32'hFFFF_FFEB);
    chk("mul_sat", 32'(sat), 32'd0);
    issue(5'b01001, 32'd0, 32'd0, lat, bcnt);
    chk("mulhi_neg", y, 32'hFFFF_FFFF);

    // Reset ten cycles into a multiply
    @(negedge clk);
    op = 5'b01000; r = 32'd3; s = 32'd5; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_in_ready", 32'(in_ready), 32'd0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mid_rst_no_output", 32'(seen), 32'd0);
    issue(5'b01001, 32'd0, 32'd0, lat, bcnt);
    chk("mulhi_after_rst", y, 32'd0);

    // Most negative squared
    issue(5'b01000, 32'h8000_0000, 32'h8000_0000, lat, bcnt);
    chk("mul_min_y", y, 32'h0000_0000);
    issue(5'b01001, 32'd0, 32'd0, lat, bcnt);
    chk("mulhi_min", y, 32'h4000_0000);

    // Zero operand with a negative partner
    issue(5'b01000, 32'h0000_0000, 32'hFFFF_FFFB, lat, bcnt);
    chk("mul_zero_lat", 32'(lat), 32'd33);
    chk("mul_zero_y", y, 32'd0);
    issue(5'b01001, 32'd0, 32'd0, lat, bcnt);
    chk("mulhi_zero", y, 32'd0);

    // Backpressure
    @(negedge clk);
    out_ready = 1'b0;
    issue(5'b00000, 32'd1, 32'd2, lat, bcnt);
    chk("bp_first_y", y, 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_y%0d", i), y, 32'd3);
      chk($sformatf("bp_hold_rdy%0d", i), 32'(in_ready), 32'd0);
      chk($sformatf("bp_hold_vld%0d", i), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    op = 5'b00000; r = 32'd10; s = 32'd20; in_valid = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_vld", 32'(out_valid), 32'd1);
    chk("bp_next_y", y, 32'd30);

    // NOP yields no output and leaves y alone
    issue(5'b11111, 32'hAAAA_AAAA, 32'h5555_5555, lat, bcnt);
    chk("nop_no_valid", 32'(lat), 32'(LIMIT));
    chk("nop_y_kept", y, 32'd30);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
